// File: rtl/alu_scheduler_pkg.sv
// rtl/alu_scheduler_pkg.sv - shared widths, opcodes, scheduler state and opcode helpers
package alu_scheduler_pkg;

   localparam int WORD_SIZE    = 19;
   localparam int OPCODE_WIDTH = 4;

   typedef logic [WORD_SIZE-1:0]    word_t;
   typedef logic [OPCODE_WIDTH-1:0] opcode_t;

   localparam opcode_t OP_NOT = 4'h0;
   localparam opcode_t OP_AND = 4'h1;
   localparam opcode_t OP_OR  = 4'h2;
   localparam opcode_t OP_XOR = 4'h3;
   localparam opcode_t OP_ADD = 4'h4;
   localparam opcode_t OP_SUB = 4'h5;
   localparam opcode_t OP_MUL = 4'h6;
   localparam opcode_t OP_DIV = 4'h7;
   localparam opcode_t OP_INC = 4'h8;
   localparam opcode_t OP_DEC = 4'h9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } sched_state_t;

   // Illegal opcodes fall into the default branch and take a single cycle.
   function automatic int op_latency(opcode_t opc, int mul_cycles, int div_cycles);
      case (opc)
         OP_MUL:  return mul_cycles;
         OP_DIV:  return div_cycles;
         default: return 1;
      endcase
   endfunction

   function automatic logic op_legal(opcode_t opc);
      return (opc <= OP_DEC);
   endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// rtl/alu_scheduler_if.sv - request, response and ALU-side bundle of the ALU scheduler
interface alu_scheduler_if #(
   parameter int NUM_REQ = 2
);
   import alu_scheduler_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode;
   logic [NUM_REQ*WORD_SIZE-1:0]    req_op1;
   logic [NUM_REQ*WORD_SIZE-1:0]    req_op2;

   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [IDX_W-1:0]                rsp_id;
   word_t                           rsp_result;
   logic                            rsp_err;

   opcode_t                         alu_opcode;
   word_t                           alu_op1;
   word_t                           alu_op2;
   word_t                           alu_result;
   logic                            busy;

   modport master (
      output req_valid, req_opcode, req_op1, req_op2, rsp_ready, alu_result,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
      input  alu_opcode, alu_op1, alu_op2, busy
   );

   modport slave (
      input  req_valid, req_opcode, req_op1, req_op2, rsp_ready, alu_result,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
      output alu_opcode, alu_op1, alu_op2, busy
   );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// rtl/alu_scheduler_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o
);

   logic found;
   int   idx;

   // Search upward from the requester after the last winner, wrapping around.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant_i) + off) % NUM_REQ;
         if (en_i && !found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDX_W'(idx);
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin scheduler sharing one ALU among NUM_REQ requesters
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 6
) (
   input  logic          clk,
   input  logic          reset,
   alu_scheduler_if.slave bus
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   sched_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   opcode_t          opc_q, opc_d;
   word_t            op1_q, op1_d;
   word_t            op2_q, op2_d;
   logic [IDX_W-1:0] id_q, id_d;
   word_t            res_q, res_d;
   logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
   logic             err_q, err_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               arb_en;
   logic               accept;
   logic               capture;
   logic               busy;
   logic               rsp_valid;
   opcode_t            opc_sel;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i        (bus.req_valid),
      .last_grant_i (last_grant_q),
      .en_i         (arb_en),
      .grant_o      (grant),
      .grant_idx_o  (grant_idx)
   );

   assign accept  = |grant;
   assign opc_sel = bus.req_opcode[grant_idx*OPCODE_WIDTH +: OPCODE_WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)          state_d = S_EXEC;
         S_EXEC:  if (cnt_q == '0)     state_d = S_RESP;
         S_RESP:  if (bus.rsp_ready)   state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      arb_en    = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_IDLE: begin
            arb_en = 1'b1;
            busy   = 1'b0;
         end
         S_EXEC:  capture   = (cnt_q == '0);
         S_RESP:  rsp_valid = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   // Illegal opcodes report zero rather than whatever the ALU produced.
   always_comb begin
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      opc_d        = opc_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      id_d         = id_q;
      res_d        = res_q;
      rsp_id_d     = rsp_id_q;
      err_d        = err_q;
      if (accept) begin
         last_grant_d = grant_idx;
         id_d         = grant_idx;
         opc_d        = opc_sel;
         op1_d        = bus.req_op1[grant_idx*WORD_SIZE +: WORD_SIZE];
         op2_d        = bus.req_op2[grant_idx*WORD_SIZE +: WORD_SIZE];
         cnt_d        = CNT_W'(op_latency(opc_sel, MUL_CYCLES, DIV_CYCLES) - 1);
      end else if (state_q == S_EXEC && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      if (capture) begin
         res_d    = op_legal(opc_q) ? bus.alu_result : '0;
         err_d    = ~op_legal(opc_q);
         rsp_id_d = id_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         opc_q        <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         id_q         <= '0;
         res_q        <= '0;
         rsp_id_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         opc_q        <= opc_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         id_q         <= id_d;
         res_q        <= res_d;
         rsp_id_q     <= rsp_id_d;
         err_q        <= err_d;
      end
   end

   assign bus.req_ready  = grant;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = res_q;
   assign bus.rsp_err    = err_q;
   assign bus.alu_opcode = opc_q;
   assign bus.alu_op1    = op1_q;
   assign bus.alu_op2    = op2_q;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - directed self-checking bench for alu_scheduler
module tb_alu_scheduler;
   import alu_scheduler_pkg::*;

   logic clk;
   logic reset;
   int   passed;
   int   total;
   logic [1:0] exp_gnt;

   alu_scheduler_if #(.NUM_REQ(2)) bus ();

   alu_scheduler #(
      .NUM_REQ    (2),
      .MUL_CYCLES (3),
      .DIV_CYCLES (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; the unmatched value makes a leaked illegal result visible.
   always_comb begin
      case (bus.alu_opcode)
         OP_NOT:  bus.alu_result = ~bus.alu_op1;
         OP_AND:  bus.alu_result = bus.alu_op1 & bus.alu_op2;
         OP_OR:   bus.alu_result = bus.alu_op1 | bus.alu_op2;
         OP_XOR:  bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
         OP_ADD:  bus.alu_result = bus.alu_op1 + bus.alu_op2;
         OP_SUB:  bus.alu_result = bus.alu_op1 - bus.alu_op2;
         OP_MUL:  bus.alu_result = bus.alu_op1 * bus.alu_op2;
         OP_DIV:  bus.alu_result = (bus.alu_op2 == '0) ? '1 : bus.alu_op1 / bus.alu_op2;
         OP_INC:  bus.alu_result = bus.alu_op1 + 1'b1;
         OP_DEC:  bus.alu_result = bus.alu_op1 - 1'b1;
         default: bus.alu_result = 19'h5A5A5;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input opcode_t opc, input word_t a, input word_t b);
      bus.req_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = opc;
      bus.req_op1[i*WORD_SIZE +: WORD_SIZE]          = a;
      bus.req_op2[i*WORD_SIZE +: WORD_SIZE]          = b;
   endtask

   task automatic wait_rsp(input string tag, input int exp_cyc);
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      passed         = 0;
      total          = 0;
      reset          = 1'b0;
      bus.req_valid  = '0;
      bus.req_opcode = '0;
      bus.req_op1    = '0;
      bus.req_op2    = '0;
      bus.rsp_ready  = 1'b1;
      step();
      step();
      check("rst_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy}, '0);
      check("rst_rsp", {bus.rsp_id, bus.rsp_result}, '0);
      check("rst_alu", {bus.alu_opcode, bus.alu_op1, bus.alu_op2}, '0);
      reset = 1'b1;
      step();

      // Contention: both requesters always valid, grants must alternate.
      set_req(0, OP_XOR, 19'h12345, 19'h0F0F0);
      set_req(1, OP_XOR, 19'h7FFFF, 19'h00001);
      bus.req_valid = 2'b11;
      #1;
      for (int n = 0; n < 4; n++) begin
         exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
         check("rr_grant", bus.req_ready, exp_gnt);
         step();
         wait_rsp("rr", 1);
         check("rr_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_err},
               {exp_gnt[1], (n % 2 == 0) ? 19'h1D3B5 : 19'h7FFFE, 1'b0});
         step();
      end
      bus.req_valid = '0;

      // Single ADD from requester 0.
      set_req(0, OP_ADD, 19'h00005, 19'h00003);
      bus.req_valid = 2'b01;
      #1;
      check("add_ready", bus.req_ready, 2'b01);
      step();
      bus.req_valid = '0;
      check("add_exec", {bus.alu_opcode, bus.alu_op1, bus.alu_op2, bus.busy, bus.rsp_valid},
            {OP_ADD, 19'h00005, 19'h00003, 1'b1, 1'b0});
      step();
      check("add_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
            {1'b1, 1'b0, 19'h00008, 1'b0});
      step();
      check("add_idle", {bus.rsp_valid, bus.busy}, 2'b00);

      // DIV from requester 1; requester inputs scrambled after accept.
      set_req(1, OP_DIV, 19'h00064, 19'h00005);
      bus.req_valid = 2'b10;
      #1;
      check("div_ready", bus.req_ready, 2'b10);
      step();
      bus.req_valid = '0;
      set_req(1, OP_SUB, 19'h00001, 19'h00002);
      for (int c = 0; c < 6; c++) begin
         check("div_hold", {bus.alu_opcode, bus.alu_op1, bus.alu_op2, bus.busy, bus.rsp_valid},
               {OP_DIV, 19'h00064, 19'h00005, 1'b1, 1'b0});
         step();
      end
      check("div_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
            {1'b1, 1'b1, 19'h00014, 1'b0});
      step();

      // MUL with response back-pressure while requester 1 waits.
      bus.rsp_ready = 1'b0;
      set_req(0, OP_MUL, 19'h00007, 19'h00009);
      bus.req_valid = 2'b01;
      #1;
      check("mul_ready", bus.req_ready, 2'b01);
      step();
      set_req(1, OP_INC, 19'h7FFFF, 19'h00000);
      bus.req_valid = 2'b10;
      wait_rsp("mul", 3);
      for (int c = 0; c < 10; c++) begin
         check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.busy, bus.req_ready},
               {1'b1, 1'b0, 19'h0003F, 1'b0, 1'b1, 2'b00});
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_release", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready},
            {1'b1, 1'b0, 19'h0003F, 2'b00});
      step();
      check("bp_idle", {bus.busy, bus.rsp_valid, bus.req_ready}, {1'b0, 1'b0, 2'b10});
      step();
      bus.req_valid = '0;
      step();
      check("inc_wrap", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
            {1'b1, 1'b1, 19'h00000, 1'b0});
      step();

      // Illegal opcode.
      set_req(0, 4'hF, 19'h01234, 19'h00001);
      bus.req_valid = 2'b01;
      #1;
      check("ill_ready", bus.req_ready, 2'b01);
      step();
      bus.req_valid = '0;
      step();
      check("ill_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
            {1'b1, 1'b0, 19'h00000, 1'b1});
      step();

      // Reset during the third DIV execute cycle.
      set_req(0, OP_DIV, 19'h00064, 19'h00005);
      bus.req_valid = 2'b01;
      #1;
      check("rdiv_ready", bus.req_ready, 2'b01);
      step();
      bus.req_valid = '0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_mid_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id}, '0);
      check("rst_mid_dp", {bus.rsp_result, bus.alu_opcode, bus.alu_op1, bus.alu_op2}, '0);
      step();
      step();
      check("rst_mid_hold", {bus.rsp_valid, bus.busy}, 2'b00);
      reset = 1'b1;
      set_req(0, OP_XOR, 19'h12345, 19'h0F0F0);
      set_req(1, OP_XOR, 19'h7FFFF, 19'h00001);
      bus.req_valid = 2'b11;
      #1;
      check("rst_tie", bus.req_ready, 2'b01);
      step();
      bus.req_valid = '0;
      wait_rsp("post_rst", 1);
      check("post_rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
            {1'b1, 1'b0, 19'h1D3B5, 1'b0});
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Multi-requester scheduler for the shared arithmetic/logic unit. Accepts operation requests from `NUM_REQ` requesters over valid/ready handshakes, grants one at a time in round-robin order, and latches the winning opcode and operands. It drives the ALU opcode and operand inputs for the number of cycles that opcode needs, then returns the captured result on a single response channel tagged with the requester index. It sits between the control unit and decode/execute stages and `arith_logic_unit`; it replaces their direct wiring to the ALU.

## Interface

Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `MUL_CYCLES`, 3: execute cycles for MUL (≥1).
- `DIV_CYCLES`, 6: execute cycles for DIV (≥1).
- All other opcodes take 1 execute cycle.
- `WORD_SIZE` (19) and the opcode type/width come from the `constants` and `opcodes` packages; they are not parameters.

Ports (clock and reset):
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset; 0 clears all state immediately.

Request side:
- `req_valid`, in, NUM_REQ: per-requester request valid.
- `req_ready`, out, NUM_REQ: per-requester accept; at most one bit high per cycle.
- `req_opcode`, in, NUM_REQ×OPCODE_WIDTH: packed opcodes; requester i occupies slice i.
- `req_op1`, in, NUM_REQ×WORD_SIZE: packed first operands.
- `req_op2`, in, NUM_REQ×WORD_SIZE: packed second operands.

Response side:
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response consumer ready.
- `rsp_id`, out, $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_result`, out, WORD_SIZE: captured ALU result.
- `rsp_err`, out, 1: opcode was not NOT/AND/OR/XOR/ADD/SUB/MUL/DIV/INC/DEC.

ALU side and status:
- `alu_opcode`, out, OPCODE_WIDTH: opcode to the ALU.
- `alu_op1`, out, WORD_SIZE: first operand to the ALU.
- `alu_op2`, out, WORD_SIZE: second operand to the ALU.
- `alu_result`, in, WORD_SIZE: ALU combinational result.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any `req_valid` is high, the round-robin winner's `req_ready` is driven high combinationally.
  - On that edge the block latches the winner's opcode, op1, op2 and index.
  - It loads `cnt` with latency−1 and moves to EXEC.
  - No `req_ready` is high outside IDLE.
- **Round robin**
  - The search starts at `(last_grant+1) mod NUM_REQ` and increments upward with wrap.
  - `last_grant` updates only on an accept.
  - The reset value of `last_grant` is NUM_REQ−1, so requester 0 has first priority.
- **EXEC**
  - `alu_opcode`, `alu_op1` and `alu_op2` are driven from the latched registers; they stay stable for the whole state.
  - If `cnt` is nonzero, it decrements.
  - When `cnt` is 0, the block captures `alu_result`, `rsp_id` and `rsp_err` and moves to RESP.
  - An illegal opcode takes 1 cycle; `rsp_result` is 0 and `rsp_err` is 1.
- **RESP**
  - `rsp_valid` is 1, and all `rsp_*` outputs are held constant until `rsp_valid && rsp_ready`.
  - On that handshake the FSM returns to IDLE.
  - A new accept cannot occur in the same cycle as the handshake; there is a 1-cycle IDLE bubble.
- **Width rules**
  - The result is passed through unmodified, WORD_SIZE bits.
  - The scheduler does not extend, saturate or check the result.
- **Request rules**
  - A requester must hold its valid, opcode and operands stable until it sees ready.
  - Dropping valid before ready is legal and simply withdraws the request.
- **Reset values**
  - State is IDLE; `req_ready`, `rsp_valid`, `rsp_err` and `busy` are 0.
  - `rsp_id`, `rsp_result`, `alu_opcode`, `alu_op1` and `alu_op2` are 0.
  - `cnt` is 0 and `last_grant` is NUM_REQ−1.
- **Reset mid-operation**: an in-flight op or pending response is discarded with no response, and `last_grant` is restored.

## Timing

- Accept edge k is the edge where valid and ready are both high.
- EXEC occupies the cycles between edge k and edge k+L, where L is the opcode latency.
- The result is captured at edge k+L; `rsp_valid` is first high in the cycle after edge k+L.
- Minimum accept-to-accept spacing is L+2 cycles with `rsp_ready` held high.
- Back-pressure on `rsp_ready` extends RESP indefinitely.
- Simultaneous requests are resolved in one cycle by round robin; losers stay pending with `req_ready` low.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.

## Structure

- Add a `sched_state_t` enum (IDLE/EXEC/RESP) to the `constants` package.
- Add a function `op_latency(opcode)` to the `opcodes` package.
- Add a function `op_legal(opcode)` to the `opcodes` package.
- Create one sub-module, `rr_arbiter`, parameterised by NUM_REQ.
  - Inputs: request vector, `last_grant`, enable.
  - Outputs: one-hot grant and grant index.
  - It is purely combinational.
- `last_grant` register and FSM live in `alu_scheduler`.

## Test plan

- **Single ADD**: req0 ADD 0x00005, 0x00003, `rsp_ready`=1 → `rsp_valid` one cycle after accept+1, result 0x00008, id 0, err 0.
- **Contention**: req0 and req1 valid together at reset, both issuing XOR → grants go 0,1,0,1 for four back-to-back ops; never two `req_ready` bits high.
- **Multi-cycle latency**: req1 DIV 0x00064, 0x00005 with DIV_CYCLES=6 → alu inputs stable for 6 cycles, result 0x00014 captured at edge k+6.
- **Back-pressure**: MUL response with `rsp_ready`=0 for 10 cycles → `rsp_*` held constant, `busy`=1, no `req_ready`; `rsp_ready`=1 → IDLE next cycle.
- **Illegal opcode**: unused opcode value → 1-cycle EXEC, `rsp_result`=0, `rsp_err`=1.
- **Reset mid-operation**: `reset` low during DIV EXEC cycle 3 → all outputs 0 immediately, no response ever issued; after release, requester 0 wins a tie with requester 1.
